// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) round-robin arbiter onto a single
// valid/ready memory port with one outstanding transaction and a response timeout.
module mem_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_Clock,
  input  logic              i_Reset,

  input  logic              i_Instr_Req,
  input  logic [XLEN-1:0]   i_Instr_Addr,
  output logic [XLEN-1:0]   o_Instr_Data,
  output logic              o_Instr_Valid,
  output logic              o_Instr_Error,

  input  logic              i_Data_Req,
  input  logic              i_Data_We,
  input  logic [XLEN-1:0]   i_Data_Addr,
  input  logic [XLEN-1:0]   i_Data_Wdata,
  input  logic [XLEN/8-1:0] i_Data_Wstrb,
  output logic [XLEN-1:0]   o_Data_Rdata,
  output logic              o_Data_Valid,
  output logic              o_Data_Error,

  output logic              o_Mem_Req_Valid,
  input  logic              i_Mem_Req_Ready,
  output logic              o_Mem_We,
  output logic [XLEN-1:0]   o_Mem_Addr,
  output logic [XLEN-1:0]   o_Mem_Wdata,
  output logic [XLEN/8-1:0] o_Mem_Wstrb,
  input  logic              i_Mem_Resp_Valid,
  input  logic [XLEN-1:0]   i_Mem_Resp_Data,
  input  logic              i_Mem_Resp_Error,

  output logic              o_Busy
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            r_State;
  state_t            w_State_Next;
  logic [CW-1:0]     r_Count;
  logic [CW-1:0]     w_Count_Next;
  logic [CW-1:0]     w_Count_Inc;

  // r_Gnt_Data doubles as the round-robin "last granted" flag (0 = instruction).
  logic              r_Gnt_Data;
  logic              r_We;
  logic [XLEN-1:0]   r_Addr;
  logic [XLEN-1:0]   r_Wdata;
  logic [XLEN/8-1:0] r_Wstrb;

  logic              w_Instr_Elig;
  logic              w_Data_Elig;
  logic              w_Grant;
  logic              w_Grant_Data;
  logic              w_Done;
  logic              w_Timeout;

  // A requester whose completion pulse is visible this cycle is still holding
  // its request; masking it stops an accidental second issue.
  assign w_Instr_Elig = i_Instr_Req & ~o_Instr_Valid;
  assign w_Data_Elig  = i_Data_Req  & ~o_Data_Valid;
  assign w_Count_Inc  = r_Count + CW'(1);

  always_comb begin
    w_State_Next = r_State;
    w_Count_Next = r_Count;
    w_Grant      = 1'b0;
    w_Grant_Data = 1'b0;
    w_Done       = 1'b0;
    w_Timeout    = 1'b0;
    unique case (r_State)
      S_IDLE: begin
        if (w_Instr_Elig || w_Data_Elig) begin
          w_Grant      = 1'b1;
          w_Grant_Data = w_Data_Elig & (~w_Instr_Elig | ~r_Gnt_Data);
          w_State_Next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_Mem_Req_Ready) begin
          w_Count_Next = '0;
          w_State_Next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_Mem_Resp_Valid) begin
          w_Done       = 1'b1;
          w_State_Next = S_IDLE;
        end else if (w_Count_Inc == CW'(TIMEOUT_CYCLES)) begin
          w_Done       = 1'b1;
          w_Timeout    = 1'b1;
          w_State_Next = S_IDLE;
        end else begin
          w_Count_Next = w_Count_Inc;
        end
      end
      default: begin
        w_State_Next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= S_IDLE;
      r_Count <= '0;
    end else begin
      r_State <= w_State_Next;
      r_Count <= w_Count_Next;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Gnt_Data <= 1'b0;
      r_We       <= 1'b0;
      r_Addr     <= '0;
      r_Wdata    <= '0;
      r_Wstrb    <= '0;
    end else if (w_Grant) begin
      r_Gnt_Data <= w_Grant_Data;
      r_We       <= w_Grant_Data & i_Data_We;
      r_Addr     <= w_Grant_Data ? i_Data_Addr  : i_Instr_Addr;
      r_Wdata    <= w_Grant_Data ? i_Data_Wdata : '0;
      r_Wstrb    <= w_Grant_Data ? i_Data_Wstrb : '0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Instr_Valid <= 1'b0;
      o_Instr_Data  <= '0;
      o_Instr_Error <= 1'b0;
      o_Data_Valid  <= 1'b0;
      o_Data_Rdata  <= '0;
      o_Data_Error  <= 1'b0;
    end else begin
      o_Instr_Valid <= 1'b0;
      o_Data_Valid  <= 1'b0;
      if (w_Done) begin
        if (r_Gnt_Data) begin
          o_Data_Valid <= 1'b1;
          o_Data_Rdata <= w_Timeout ? '0 : i_Mem_Resp_Data;
          o_Data_Error <= w_Timeout | i_Mem_Resp_Error;
        end else begin
          o_Instr_Valid <= 1'b1;
          o_Instr_Data  <= w_Timeout ? '0 : i_Mem_Resp_Data;
          o_Instr_Error <= w_Timeout | i_Mem_Resp_Error;
        end
      end
    end
  end

  assign o_Mem_Req_Valid = (r_State == S_ISSUE);
  assign o_Mem_We        = r_We;
  assign o_Mem_Addr      = r_Addr;
  assign o_Mem_Wdata     = r_Wdata;
  assign o_Mem_Wstrb     = r_Wstrb;
  assign o_Busy          = (r_State != S_IDLE);

endmodule
